sram_arbiter: RTL and testbench

- Shares the single external 16-bit SRAM between two requesters:
  - the video fetch port, which fills the VGA line buffer and is time-critical;
  - the drawing port, which `write_buffer` drives with its existing address / read / write / ready protocol.
- Owns the SRAM pins and sequences every access with fixed timing: reads, writes, and write recovery.
- Priority rule: video wins; the drawing port gets a guaranteed slot after a bounded run of video accesses, so line drawing never starves.

---
 rtl/sram_arbiter_if.sv | 44 ++++
 rtl/sram_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// ============================================================================
// Module : sram_arbiter_if
// Bundles the video fetch port, drawing port and SRAM pins of sram_arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sram_arbiter_if;
  // video fetch port
  logic        vid_req;
  logic [17:0] vid_addr;
  logic        vid_ack;
  logic [15:0] vid_data;
  logic        vid_valid;
  // drawing port
  logic [17:0] wb_address;
  logic        wb_read;
  logic        wb_write;
  logic [15:0] wb_data_write;
  logic [15:0] wb_data_read;
  logic        wb_ready;
  // SRAM pins
  logic [17:0] sram_addr;
  logic [15:0] sram_dq_out;
  logic        sram_dq_oe;
  logic [15:0] sram_dq_in;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;

  modport slave (
    input  vid_req, vid_addr, wb_address, wb_read, wb_write, wb_data_write, sram_dq_in,
    output vid_ack, vid_data, vid_valid, wb_data_read, wb_ready,
           sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
  );

  modport master (
    output vid_req, vid_addr, wb_address, wb_read, wb_write, wb_data_write, sram_dq_in,
    input  vid_ack, vid_data, vid_valid, wb_data_read, wb_ready,
           sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n
  );
endinterface

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// Module : sram_arbiter
// Shares one 16-bit SRAM between the video fetch port (priority) and the
// drawing port, with a bounded video run so drawing never starves.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sram_arbiter #(
  parameter int ACCESS_CYCLES = 2,
  parameter int MAX_VID_RUN   = 8
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  sram_arbiter_if.slave bus
);

  localparam int C_CNT_W = (ACCESS_CYCLES > 1) ? $clog2(ACCESS_CYCLES) : 1;
  localparam int C_RUN_W = ($clog2(MAX_VID_RUN + 1) > 4) ? $clog2(MAX_VID_RUN + 1) : 4;
  localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(ACCESS_CYCLES - 1);
  localparam logic [C_RUN_W-1:0] C_RUN_MAX  = C_RUN_W'(MAX_VID_RUN);
  localparam logic [C_RUN_W-1:0] C_RUN_SAT  = {C_RUN_W{1'b1}};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_VRD  = 3'd1,
    S_WRD  = 3'd2,
    S_WWR  = 3'd3,
    S_WREC = 3'd4
  } state_t;

  state_t               r_state;
  logic [C_CNT_W-1:0]   r_cnt;
  logic [C_RUN_W-1:0]   r_vid_run;

  logic                 r_pend;
  logic                 r_pend_wr;
  logic [17:0]          r_pend_addr;
  logic [15:0]          r_pend_data;

  logic                 r_vid_ack;
  logic                 r_vid_valid;
  logic [15:0]          r_vid_data;
  logic [15:0]          r_wb_data_read;
  logic                 r_wb_ready;
  logic [17:0]          r_sram_addr;
  logic [15:0]          r_sram_dq_out;
  logic                 r_sram_dq_oe;
  logic                 r_sram_ce_n;
  logic                 r_sram_oe_n;
  logic                 r_sram_we_n;

  logic                 w_capture;
  logic                 w_vid_grant;

  assign w_capture   = r_wb_ready & (bus.wb_read | bus.wb_write);
  assign w_vid_grant = bus.vid_req & (~r_pend | (r_vid_run < C_RUN_MAX));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_vid_run      <= '0;
      r_pend         <= 1'b0;
      r_pend_wr      <= 1'b0;
      r_pend_addr    <= '0;
      r_pend_data    <= '0;
      r_vid_ack      <= 1'b0;
      r_vid_valid    <= 1'b0;
      r_vid_data     <= '0;
      r_wb_data_read <= '0;
      r_wb_ready     <= 1'b1;
      r_sram_addr    <= '0;
      r_sram_dq_out  <= '0;
      r_sram_dq_oe   <= 1'b0;
      r_sram_ce_n    <= 1'b1;
      r_sram_oe_n    <= 1'b1;
      r_sram_we_n    <= 1'b1;
    end else begin
      r_vid_ack   <= 1'b0;
      r_vid_valid <= 1'b0;

      // A held request is latched once; write wins if both strobes are set.
      if (w_capture) begin
        r_pend      <= 1'b1;
        r_pend_wr   <= bus.wb_write;
        r_pend_addr <= bus.wb_address;
        r_pend_data <= bus.wb_data_write;
        r_wb_ready  <= 1'b0;
      end

      if (!r_pend) begin
        r_vid_run <= '0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_vid_grant) begin
            r_state     <= S_VRD;
            r_cnt       <= '0;
            r_sram_addr <= bus.vid_addr;
            r_sram_ce_n <= 1'b0;
            r_sram_oe_n <= 1'b0;
            r_vid_ack   <= 1'b1;
            if (r_pend && (r_vid_run != C_RUN_SAT)) begin
              r_vid_run <= r_vid_run + 1'b1;
            end
          end else if (r_pend) begin
            r_pend      <= 1'b0;
            r_vid_run   <= '0;
            r_cnt       <= '0;
            r_sram_addr <= r_pend_addr;
            r_sram_ce_n <= 1'b0;
            if (r_pend_wr) begin
              r_state       <= S_WWR;
              r_sram_dq_out <= r_pend_data;
              r_sram_dq_oe  <= 1'b1;
              r_sram_we_n   <= 1'b0;
            end else begin
              r_state     <= S_WRD;
              r_sram_oe_n <= 1'b0;
            end
          end
        end

        S_VRD: begin
          if (r_cnt == C_CNT_LAST) begin
            r_state     <= S_IDLE;
            r_vid_data  <= bus.sram_dq_in;
            r_vid_valid <= 1'b1;
            r_sram_ce_n <= 1'b1;
            r_sram_oe_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WRD: begin
          if (r_cnt == C_CNT_LAST) begin
            r_state        <= S_IDLE;
            r_wb_data_read <= bus.sram_dq_in;
            r_wb_ready     <= 1'b1;
            r_sram_ce_n    <= 1'b1;
            r_sram_oe_n    <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WWR: begin
          // Release we_n first; ce_n, address and data hold through recovery.
          if (r_cnt == C_CNT_LAST) begin
            r_state     <= S_WREC;
            r_sram_we_n <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        S_WREC: begin
          r_state      <= S_IDLE;
          r_sram_ce_n  <= 1'b1;
          r_sram_dq_oe <= 1'b0;
          r_wb_ready   <= 1'b1;
        end

        default: begin
          r_state      <= S_IDLE;
          r_sram_ce_n  <= 1'b1;
          r_sram_oe_n  <= 1'b1;
          r_sram_we_n  <= 1'b1;
          r_sram_dq_oe <= 1'b0;
        end
      endcase
    end
  end

  assign bus.vid_ack      = r_vid_ack;
  assign bus.vid_valid    = r_vid_valid;
  assign bus.vid_data     = r_vid_data;
  assign bus.wb_data_read = r_wb_data_read;
  assign bus.wb_ready     = r_wb_ready;
  assign bus.sram_addr    = r_sram_addr;
  assign bus.sram_dq_out  = r_sram_dq_out;
  assign bus.sram_dq_oe   = r_sram_dq_oe;
  assign bus.sram_ce_n    = r_sram_ce_n;
  assign bus.sram_oe_n    = r_sram_oe_n;
  assign bus.sram_we_n    = r_sram_we_n;

endmodule

`default_nettype wire

// File: tb/tb_sram_arbiter.sv
// ============================================================================
// Module : tb_sram_arbiter
// Directed bench for sram_arbiter with an SRAM model and read scoreboards.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sram_arbiter;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sram_arbiter_if bus ();

  sram_arbiter #(.ACCESS_CYCLES(2), .MAX_VID_RUN(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  logic [15:0] mem [0:8191];
  bit          mem_init = 1'b0;
  logic [15:0] vid_q [$];
  logic [15:0] wb_q  [$];
  int          n_writes = 0;
  logic        prev_we_n = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // SRAM model: asynchronous read, write committed on clock edges with we_n low.
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 8192; i++) mem[i] <= 16'h0000;
      mem[13'h12C0] <= 16'hBEEF;
      mem[13'h0010] <= 16'h1234;
      mem_init      <= 1'b1;
    end else if (!bus.sram_ce_n && !bus.sram_we_n) begin
      mem[bus.sram_addr[12:0]] <= bus.sram_dq_out;
    end
  end

  assign bus.sram_dq_in = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_addr[12:0]] : 16'h0000;

  // Video scoreboard plus pin-level invariants.
  always @(negedge clk) begin
    if (reset_n === 1'b1) begin
      if (bus.vid_ack) vid_q.push_back(mem[bus.vid_addr[12:0]]);
      if (bus.vid_valid) begin
        if (vid_q.size() == 0) chk("vid_valid_unexpected", 32'd1, 32'd0);
        else chk("vid_data_sb", {16'h0, bus.vid_data}, {16'h0, vid_q.pop_front()});
      end
      chk("oe_we_exclusive", {31'h0, bus.sram_oe_n | bus.sram_we_n}, 32'd1);
      if (!bus.sram_oe_n) chk("dq_oe_during_read", {31'h0, bus.sram_dq_oe}, 32'd0);
      if (!bus.sram_we_n && prev_we_n) n_writes++;
    end
    prev_we_n = bus.sram_we_n;
  end

  task automatic wb_op(input string tag, input bit wr, input logic [17:0] addr,
                       input logic [15:0] data, output int n);
    bus.wb_address    = addr;
    bus.wb_data_write = data;
    bus.wb_write      = wr;
    bus.wb_read       = ~wr;
    if (!wr) wb_q.push_back(mem[addr[12:0]]);
    tick();
    bus.wb_write = 1'b0;
    bus.wb_read  = 1'b0;
    chk({tag, "_ready_low"}, {31'h0, bus.wb_ready}, 32'd0);
    n = 0;
    while (!bus.wb_ready && n < 50) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int n;
    int acks;
    int guard;
    int w0;
    logic [15:0] exp;

    bus.vid_req = 0; bus.vid_addr = 18'h12C0;
    bus.wb_address = 0; bus.wb_read = 0; bus.wb_write = 0; bus.wb_data_write = 0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_wb_ready", {31'h0, bus.wb_ready}, 32'd1);
    chk("rst_vid_ack", {31'h0, bus.vid_ack}, 32'd0);
    chk("rst_vid_valid", {31'h0, bus.vid_valid}, 32'd0);
    chk("rst_vid_data", {16'h0, bus.vid_data}, 32'd0);
    chk("rst_wb_data_read", {16'h0, bus.wb_data_read}, 32'd0);
    chk("rst_sram_addr", {14'h0, bus.sram_addr}, 32'd0);
    chk("rst_dq_out", {16'h0, bus.sram_dq_out}, 32'd0);
    chk("rst_dq_oe", {31'h0, bus.sram_dq_oe}, 32'd0);
    chk("rst_pins_n", {29'h0, bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n}, 32'd7);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();

    // Single video read
    bus.vid_addr = 18'h12C0;
    bus.vid_req  = 1'b1;
    tick();
    chk("vid_ack_t1", {31'h0, bus.vid_ack}, 32'd1);
    chk("vrd_addr", {14'h0, bus.sram_addr}, 32'h12C0);
    chk("vrd_oe_n", {31'h0, bus.sram_oe_n}, 32'd0);
    bus.vid_req = 1'b0;
    tick();
    chk("vid_ack_t2", {31'h0, bus.vid_ack}, 32'd0);
    chk("vid_valid_t2", {31'h0, bus.vid_valid}, 32'd0);
    tick();
    chk("vid_valid_t3", {31'h0, bus.vid_valid}, 32'd1);
    chk("vid_data_t3", {16'h0, bus.vid_data}, 32'hBEEF);
    tick();

    // Drawing write then read back
    wb_op("wr_f0", 1'b1, 18'h000F0, 16'h00A5, n);
    chk("wr_latency", n, 32'd4);
    tick();
    wb_op("rd_f0", 1'b0, 18'h000F0, 16'h0000, n);
    chk("rd_latency", n, 32'd3);
    exp = wb_q.pop_front();
    chk("rd_f0_data", {16'h0, bus.wb_data_read}, {16'h0, exp});
    chk("rd_f0_const", {16'h0, bus.wb_data_read}, 32'h00A5);
    tick();

    // Starvation bound: write captured while video is streaming
    bus.vid_addr = 18'h12C0;
    bus.vid_req  = 1'b1;
    tick();
    bus.wb_address = 18'h00300; bus.wb_data_write = 16'h5A5A; bus.wb_write = 1'b1;
    tick();
    bus.wb_write = 1'b0;
    acks = 0; guard = 0;
    while (bus.sram_we_n && guard < 300) begin
      if (bus.vid_ack) acks++;
      tick();
      guard++;
    end
    chk("starve_acks", acks, 32'd8);
    guard = 0;
    while (!bus.vid_ack && guard < 20) begin
      tick();
      guard++;
    end
    chk("starve_vid_resume", {31'h0, bus.vid_ack}, 32'd1);
    chk("starve_wb_ready", {31'h0, bus.wb_ready}, 32'd1);
    bus.vid_req = 1'b0;
    repeat (4) tick();
    chk("starve_mem", {16'h0, mem[13'h0300]}, 32'h5A5A);

    // Contention: video and drawing write in the same cycle
    w0 = n_writes;
    bus.vid_req = 1'b1; bus.vid_addr = 18'h12C0;
    bus.wb_address = 18'h00040; bus.wb_data_write = 16'h7777; bus.wb_write = 1'b1;
    tick();
    bus.vid_req = 1'b0; bus.wb_write = 1'b0;
    chk("cont_vid_first", {31'h0, bus.vid_ack}, 32'd1);
    chk("cont_ready_low", {31'h0, bus.wb_ready}, 32'd0);
    chk("cont_we_idle", {31'h0, bus.sram_we_n}, 32'd1);
    tick();
    tick();
    chk("cont_vid_valid", {31'h0, bus.vid_valid}, 32'd1);
    chk("cont_we_before", {31'h0, bus.sram_we_n}, 32'd1);
    tick();
    chk("cont_wwr_start", {31'h0, bus.sram_we_n}, 32'd0);
    chk("cont_wwr_dq_oe", {31'h0, bus.sram_dq_oe}, 32'd1);
    guard = 0;
    while (!bus.wb_ready && guard < 20) begin
      tick();
      guard++;
    end
    chk("cont_ready_back", {31'h0, bus.wb_ready}, 32'd1);
    chk("cont_mem", {16'h0, mem[13'h0040]}, 32'h7777);
    chk("cont_writes", n_writes - w0, 32'd1);
    tick();

    // Second strobe while busy is ignored
    w0 = n_writes;
    bus.wb_address = 18'h00050; bus.wb_data_write = 16'h1111; bus.wb_write = 1'b1;
    tick();
    bus.wb_address = 18'h00051; bus.wb_data_write = 16'h2222;
    tick();
    bus.wb_write = 1'b0;
    guard = 0;
    while (!bus.wb_ready && guard < 20) begin
      tick();
      guard++;
    end
    repeat (3) tick();
    chk("busy_writes", n_writes - w0, 32'd1);
    chk("busy_mem_first", {16'h0, mem[13'h0050]}, 32'h1111);
    chk("busy_mem_second", {16'h0, mem[13'h0051]}, 32'h0000);

    // Reset in the middle of a write
    bus.wb_address = 18'h00020; bus.wb_data_write = 16'hDEAD; bus.wb_write = 1'b1;
    tick();
    bus.wb_write = 1'b0;
    tick();
    chk("mid_wwr", {31'h0, bus.sram_we_n}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("abort_we_n", {31'h0, bus.sram_we_n}, 32'd1);
    chk("abort_ce_n", {31'h0, bus.sram_ce_n}, 32'd1);
    chk("abort_dq_oe", {31'h0, bus.sram_dq_oe}, 32'd0);
    chk("abort_wb_ready", {31'h0, bus.wb_ready}, 32'd1);
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    chk("abort_mem", {16'h0, mem[13'h0020]}, 32'h0000);
    chk("abort_no_retry", {31'h0, bus.sram_we_n}, 32'd1);
    wb_op("rd_10", 1'b0, 18'h00010, 16'h0000, n);
    chk("rd_10_latency", n, 32'd3);
    exp = wb_q.pop_front();
    chk("rd_10_data", {16'h0, bus.wb_data_read}, {16'h0, exp});
    chk("rd_10_const", {16'h0, bus.wb_data_read}, 32'h1234);

    repeat (3) tick();
    chk("vid_sb_empty", vid_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
